// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle between the two requesters, the data RAM and
// the dmem_arbiter. The "slave" modport is the arbiter's view; the "master"
// modport is the environment's view (requesters plus the RAM q return).
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0 (CPU data side)
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  // Port 1 (secondary master)
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  // Single-port synchronous RAM side
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output ram_addr, ram_wdata, ram_wren,
    input  ram_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  ram_addr, ram_wdata, ram_wren,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port synchronous
// data RAM. Each access runs IDLE -> GRANT (-> WAIT for reads) -> IDLE.
// Ties are resolved round-robin using a last-served pointer.
// Build option: define DMEM_ARB_PRIO_EN for fixed priority (port 0 wins ties).
// RD_LAT is the RAM read latency in cycles, legal range 1..3.
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_r;
  logic [1:0]    cnt_r;
  logic          we_r;
  logic          sel_r;      // port being served: 0 or 1
  logic          last_r;     // last-served pointer
  logic          gnt0_r;
  logic          gnt1_r;
  logic          rvalid0_r;
  logic          rvalid1_r;
  logic          ram_wren_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_wdata_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;

  logic          any_req_s;
  logic          win_s;      // winning port when any_req_s is high

  // Pick the winning requester for the current IDLE cycle.
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    win_s     = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_PRIO_EN
      win_s = 1'b0;
`else
      win_s = ~last_r;
`endif
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      we_r        <= 1'b0;
      sel_r       <= 1'b0;
      last_r      <= 1'b1;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      ram_wren_r  <= 1'b0;
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= {DW{1'b0}};
      rdata0_r    <= {DW{1'b0}};
      rdata1_r    <= {DW{1'b0}};
    end else begin
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
      ram_wren_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            sel_r  <= win_s;
            last_r <= win_s;
            if (win_s) begin
              we_r        <= bus.we1;
              ram_wren_r  <= bus.we1;
              ram_addr_r  <= bus.addr1;
              ram_wdata_r <= bus.wdata1;
              gnt1_r      <= 1'b1;
            end else begin
              we_r        <= bus.we0;
              ram_wren_r  <= bus.we0;
              ram_addr_r  <= bus.addr0;
              ram_wdata_r <= bus.wdata0;
              gnt0_r      <= 1'b1;
            end
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // The RAM commits a write / captures a read address on this edge.
          if (we_r) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= 2'(RD_LAT);
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 2'd1;
          if (cnt_r == 2'd1) begin
            // RAM q is valid now; only the served port's rdata changes.
            if (sel_r) begin
              rdata1_r  <= bus.ram_rdata;
              rvalid1_r <= 1'b1;
            end else begin
              rdata0_r  <= bus.ram_rdata;
              rvalid0_r <= 1'b1;
            end
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.rvalid0   = rvalid0_r;
  assign bus.rvalid1   = rvalid1_r;
  assign bus.rdata0    = rdata0_r;
  assign bus.rdata1    = rdata1_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.ram_wren  = ram_wren_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a RD_LAT=1 RAM model.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus_if ();

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Synchronous single-port RAM, read latency 1 (q registered from address).
  logic [31:0] mem [0:255];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus_if.ram_wren) mem[bus_if.ram_addr[7:0]] <= bus_if.ram_wdata;
    ram_q <= mem[bus_if.ram_addr[7:0]];
  end
  assign bus_if.ram_rdata = ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.req0 = 1'b0; bus_if.we0 = 1'b0; bus_if.addr0 = 32'h0; bus_if.wdata0 = 32'h0;
    bus_if.req1 = 1'b0; bus_if.we1 = 1'b0; bus_if.addr1 = 32'h0; bus_if.wdata1 = 32'h0;
    tick(); tick();
    checks++;
    if ({bus_if.gnt0, bus_if.gnt1, bus_if.rvalid0, bus_if.rvalid1, bus_if.ram_wren} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: actual=%b required=00000",
        {bus_if.gnt0, bus_if.gnt1, bus_if.rvalid0, bus_if.rvalid1, bus_if.ram_wren});
    end
    checks++;
    if ({bus_if.ram_addr, bus_if.ram_wdata, bus_if.rdata0, bus_if.rdata1} !== 128'h0) begin
      errors++; $display("FAIL reset_buses: actual=%h required=0",
        {bus_if.ram_addr, bus_if.ram_wdata, bus_if.rdata0, bus_if.rdata1});
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus_if.gnt0, bus_if.gnt1, bus_if.ram_wren} !== 3'b0) begin
        errors++; $display("FAIL idle_hold cycle %0d: actual=%b required=000", i,
          {bus_if.gnt0, bus_if.gnt1, bus_if.ram_wren});
      end
    end
  endtask

  task automatic test_write0();
    bus_if.req0 = 1'b1; bus_if.we0 = 1'b1; bus_if.addr0 = 32'h10; bus_if.wdata0 = 32'hDEADBEEF;
    checks++;
    if (bus_if.ram_wren !== 1'b0) begin
      errors++; $display("FAIL write0_wren_before: actual=%b required=0", bus_if.ram_wren);
    end
    tick();
    checks++;
    if ({bus_if.gnt0, bus_if.gnt1, bus_if.ram_wren} !== 3'b101) begin
      errors++; $display("FAIL write0_grant: gnt0/gnt1/wren actual=%b required=101",
        {bus_if.gnt0, bus_if.gnt1, bus_if.ram_wren});
    end
    checks++;
    if (bus_if.ram_addr !== 32'h10 || bus_if.ram_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write0_bus: actual=%h/%h required=00000010/deadbeef",
        bus_if.ram_addr, bus_if.ram_wdata);
    end
    bus_if.req0 = 1'b0;
    tick();
    checks++;
    if ({bus_if.gnt0, bus_if.ram_wren} !== 2'b00) begin
      errors++; $display("FAIL write0_after: gnt0/wren actual=%b required=00", {bus_if.gnt0, bus_if.ram_wren});
    end
  endtask

  task automatic test_read1();
    bus_if.req1 = 1'b1; bus_if.we1 = 1'b0; bus_if.addr1 = 32'h10; bus_if.wdata1 = 32'h0;
    tick();
    checks++;
    if ({bus_if.gnt1, bus_if.gnt0, bus_if.ram_wren} !== 3'b100 || bus_if.ram_addr !== 32'h10) begin
      errors++; $display("FAIL read1_grant: gnt1/gnt0/wren=%b addr=%h required=100 addr=10",
        {bus_if.gnt1, bus_if.gnt0, bus_if.ram_wren}, bus_if.ram_addr);
    end
    bus_if.req1 = 1'b0;
    tick();
    checks++;
    if ({bus_if.gnt1, bus_if.rvalid1, bus_if.ram_wren} !== 3'b000 || bus_if.ram_addr !== 32'h10) begin
      errors++; $display("FAIL read1_wait: gnt1/rvalid1/wren=%b addr=%h required=000 addr=10",
        {bus_if.gnt1, bus_if.rvalid1, bus_if.ram_wren}, bus_if.ram_addr);
    end
    tick();
    checks++;
    if (bus_if.rvalid1 !== 1'b1 || bus_if.rdata1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read1_data: rvalid1=%b rdata1=%h required=1 deadbeef",
        bus_if.rvalid1, bus_if.rdata1);
    end
    checks++;
    if (bus_if.rvalid0 !== 1'b0 || bus_if.rdata0 !== 32'h0) begin
      errors++; $display("FAIL read1_port0_quiet: rvalid0=%b rdata0=%h required=0 00000000",
        bus_if.rvalid0, bus_if.rdata0);
    end
    tick();
    checks++;
    if (bus_if.rvalid1 !== 1'b0 || bus_if.rdata1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read1_hold: rvalid1=%b rdata1=%h required=0 deadbeef",
        bus_if.rvalid1, bus_if.rdata1);
    end
  endtask

  task automatic test_write1();
    bus_if.req1 = 1'b1; bus_if.we1 = 1'b1; bus_if.addr1 = 32'h20; bus_if.wdata1 = 32'h12345678;
    tick();
    checks++;
    if ({bus_if.gnt1, bus_if.ram_wren} !== 2'b11 || bus_if.ram_addr !== 32'h20 ||
        bus_if.ram_wdata !== 32'h12345678) begin
      errors++; $display("FAIL write1_grant: gnt1/wren=%b addr=%h wdata=%h required=11 20 12345678",
        {bus_if.gnt1, bus_if.ram_wren}, bus_if.ram_addr, bus_if.ram_wdata);
    end
    bus_if.req1 = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int n;
    int order [4];
    int exp_port;
    logic [31:0] exp_addr;
    n = 0;
    bus_if.req0 = 1'b1; bus_if.we0 = 1'b1; bus_if.addr0 = 32'h30; bus_if.wdata0 = 32'hA0A0A0A0;
    bus_if.req1 = 1'b1; bus_if.we1 = 1'b1; bus_if.addr1 = 32'h34; bus_if.wdata1 = 32'hB1B1B1B1;
    for (int c = 0; c < 16 && n < 4; c++) begin
      tick();
      if (bus_if.gnt0 && bus_if.gnt1) begin
        checks++; errors++;
        $display("FAIL contention_double_grant: actual=11 required=one-hot");
      end
      if (bus_if.gnt0 || bus_if.gnt1) begin
        order[n] = bus_if.gnt1 ? 1 : 0;
        exp_addr = bus_if.gnt1 ? 32'h34 : 32'h30;
        checks++;
        if (bus_if.ram_wren !== 1'b1 || bus_if.ram_addr !== exp_addr) begin
          errors++; $display("FAIL contention_bus %0d: wren=%b addr=%h required=1 %h",
            n, bus_if.ram_wren, bus_if.ram_addr, exp_addr);
        end
        n++;
        if (n == 4) begin
          bus_if.req0 = 1'b0;
          bus_if.req1 = 1'b0;
        end
      end
    end
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL contention_count: actual=%0d required=4", n);
    end
    for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_PRIO_EN
      exp_port = 0;
`else
      exp_port = i % 2;
`endif
      checks++;
      if (order[i] != exp_port) begin
        errors++; $display("FAIL contention_order %0d: actual=%0d required=%0d", i, order[i], exp_port);
      end
    end
    tick();
  endtask

  task automatic test_req_during_wait();
    bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 32'h10;
    tick();
    checks++;
    if (bus_if.gnt0 !== 1'b1) begin
      errors++; $display("FAIL wait_gnt0: actual=%b required=1", bus_if.gnt0);
    end
    bus_if.req0 = 1'b0;
    tick();
    bus_if.req1 = 1'b1; bus_if.we1 = 1'b1; bus_if.addr1 = 32'h40; bus_if.wdata1 = 32'h55555555;
    checks++;
    if (bus_if.gnt1 !== 1'b0) begin
      errors++; $display("FAIL wait_gnt1_early: actual=%b required=0", bus_if.gnt1);
    end
    tick();
    checks++;
    if (bus_if.rvalid0 !== 1'b1 || bus_if.rdata0 !== 32'hDEADBEEF || bus_if.gnt1 !== 1'b0) begin
      errors++; $display("FAIL wait_rvalid0: rvalid0=%b rdata0=%h gnt1=%b required=1 deadbeef 0",
        bus_if.rvalid0, bus_if.rdata0, bus_if.gnt1);
    end
    tick();
    checks++;
    if ({bus_if.gnt1, bus_if.ram_wren} !== 2'b11 || bus_if.ram_addr !== 32'h40) begin
      errors++; $display("FAIL wait_gnt1_after: gnt1/wren=%b addr=%h required=11 40",
        {bus_if.gnt1, bus_if.ram_wren}, bus_if.ram_addr);
    end
    bus_if.req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 32'h20;
    tick();
    bus_if.req0 = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus_if.rvalid0, bus_if.gnt0, bus_if.ram_wren} !== 3'b000 || bus_if.rdata0 !== 32'h0) begin
      errors++; $display("FAIL midreset_async: rvalid0/gnt0/wren=%b rdata0=%h required=000 0",
        {bus_if.rvalid0, bus_if.gnt0, bus_if.ram_wren}, bus_if.rdata0);
    end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_if.rvalid0 !== 1'b0) begin
        errors++; $display("FAIL midreset_no_rvalid cycle %0d: actual=%b required=0", i, bus_if.rvalid0);
      end
    end
    bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 32'h20;
    tick();
    checks++;
    if (bus_if.gnt0 !== 1'b1 || bus_if.ram_addr !== 32'h20) begin
      errors++; $display("FAIL midreset_regrant: gnt0=%b addr=%h required=1 20", bus_if.gnt0, bus_if.ram_addr);
    end
    bus_if.req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_if.rvalid0 !== 1'b1 || bus_if.rdata0 !== 32'h12345678) begin
      errors++; $display("FAIL midreset_read: rvalid0=%b rdata0=%h required=1 12345678",
        bus_if.rvalid0, bus_if.rdata0);
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write0();
    test_read1();
    test_write1();
    test_contention();
    test_req_during_wait();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
